// File: rtl/q1_arb_if.sv
// q1_arb_if: requester and datapath signal bundle for q1_arb.
//
// Requester side (per requester n = 0, 1):
//   reqn   request, held high until gntn
//   dinn   4-bit operand, dinn[0] -> b0 .. dinn[3] -> b3
//   seln   select bit, drives s
//   gntn   one-cycle pulse: request accepted, operand latched
//   donen  one-cycle pulse: result valid on res
// Datapath side:
//   dp_b   operand to datapath b3..b0
//   dp_s   select to datapath s
//   dp_a   result from datapath a3..a0
// Status:
//   res    captured result, held until the next capture
//   busy   arbiter is not idle
//
// Modport slave is the arbiter side; modport master is the requester/datapath side.
interface q1_arb_if;
    logic       req0;
    logic [3:0] din0;
    logic       sel0;
    logic       gnt0;
    logic       done0;
    logic       req1;
    logic [3:0] din1;
    logic       sel1;
    logic       gnt1;
    logic       done1;
    logic [3:0] dp_b;
    logic       dp_s;
    logic [3:0] dp_a;
    logic [3:0] res;
    logic       busy;

    modport slave (
        input  req0, din0, sel0, req1, din1, sel1, dp_a,
        output gnt0, done0, gnt1, done1, dp_b, dp_s, res, busy
    );

    modport master (
        output req0, din0, sel0, req1, din1, sel1, dp_a,
        input  gnt0, done0, gnt1, done1, dp_b, dp_s, res, busy
    );
endinterface

// File: rtl/q1_arb.sv
// q1_arb: sequencer and two-way arbiter for the shared q1 4-bit datapath.
//
// Grants one requester at a time, drives its latched operand/select onto the
// datapath for SETTLE_CYCLES cycles, captures the datapath result into res and
// pulses done to the owning requester.
//
// Parameters:
//   SETTLE_CYCLES  cycles the operand is held before capture, legal 1..15
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   io_bus  q1_arb_if.slave: requester handshakes, datapath drive/return, res, busy
// Configuration macro:
//   Q1_ARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie
//                         undefined: round-robin on ties (default)
module q1_arb #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    q1_arb_if.slave  io_bus
);

    localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    state_e     r_state, w_state_nxt;
    logic [3:0] r_op, w_op_nxt;
    logic       r_sel, w_sel_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic       r_last, w_last_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_res, w_res_nxt;
    logic       r_gnt0, w_gnt0_nxt;
    logic       r_gnt1, w_gnt1_nxt;
    logic       r_done0, w_done0_nxt;
    logic       r_done1, w_done1_nxt;
    logic       w_any_req;
    logic       w_pick1;

    assign w_any_req = io_bus.req0 | io_bus.req1;

`ifdef Q1_ARB_FIXED_PRIO_EN
    assign w_pick1 = io_bus.req1 & ~io_bus.req0;
`else
    // On a tie, requester 1 wins only if requester 0 was granted last.
    assign w_pick1 = io_bus.req1 & (~io_bus.req0 | ~r_last);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_sel_nxt   = r_sel;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_res_nxt   = r_res;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_done0_nxt = 1'b0;
        w_done1_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_op_nxt    = w_pick1 ? io_bus.din1 : io_bus.din0;
                    w_sel_nxt   = w_pick1 ? io_bus.sel1 : io_bus.sel0;
                    w_owner_nxt = w_pick1 ? 2'b10 : 2'b01;
                    w_last_nxt  = w_pick1;
                    w_cnt_nxt   = CntLoad;
                    w_gnt0_nxt  = ~w_pick1;
                    w_gnt1_nxt  = w_pick1;
                    w_state_nxt = StDrive;
                end
            end
            StDrive: begin
                if (r_cnt == 4'd0) begin
                    w_res_nxt   = io_bus.dp_a;
                    w_done0_nxt = r_owner[0];
                    w_done1_nxt = r_owner[1];
                    w_state_nxt = StDone;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_op    <= 4'd0;
            r_sel   <= 1'b0;
            r_owner <= 2'b00;
            r_last  <= 1'b1;
            r_cnt   <= 4'd0;
            r_res   <= 4'd0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_sel   <= w_sel_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_res   <= w_res_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_done0 <= w_done0_nxt;
            r_done1 <= w_done1_nxt;
        end
    end

    // Operand is visible on the datapath through DRIVE and DONE, zero when idle.
    assign io_bus.dp_b  = (r_state == StIdle) ? 4'd0 : r_op;
    assign io_bus.dp_s  = (r_state == StIdle) ? 1'b0 : r_sel;
    assign io_bus.busy  = (r_state != StIdle);
    assign io_bus.res   = r_res;
    assign io_bus.gnt0  = r_gnt0;
    assign io_bus.gnt1  = r_gnt1;
    assign io_bus.done0 = r_done0;
    assign io_bus.done1 = r_done1;

endmodule

// File: doc/q1_arb.md
# q1_arb

Sequencer and two-way arbiter for the shared q1 4-bit datapath (b0..b3 plus select s, results a0..a3). Two requesters each present a 4-bit operand and a select bit. The block grants one requester at a time and drives the operand onto the datapath inputs. It holds them for a settle interval, captures the 4-bit result into a register and signals completion to the granted requester. It sits between the requester logic and the single combinational q1 instance.

## Interface
- SETTLE_CYCLES, 1: cycles operand/select are held on the datapath before capture; legal range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  requester 0 request; held high until gnt0.
- din0  in  4  requester 0 operand; din0[0] maps to b0 … din0[3] to b3.
- sel0  in  1  requester 0 select, drives s.
- gnt0  out  1  one-cycle pulse: requester 0 accepted, din0/sel0 latched.
- done0  out  1  one-cycle pulse: result for requester 0 valid on res.
- req1, din1, sel1, gnt1, done1: same for requester 1.
- dp_b  out  4  to datapath b3..b0.
- dp_s  out  1  to datapath s.
- dp_a  in  4  from datapath a3..a0.
- res  out  4  captured result; holds until next capture.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE: if req0 or req1 is high at a clock edge, choose a winner and latch its din/sel into the operand register. Set the one-hot owner register, load the settle counter with SETTLE_CYCLES-1 and go to DRIVE. The winner's gnt is high for the following cycle only.
- Arbitration is round-robin. Register `last` records the last granted requester and resets to 1, so requester 0 wins the first tie. With both requesting, grant the one not equal to `last`. With one requesting, grant it regardless of `last`.
- DRIVE: dp_b/dp_s = latched operand/select. The counter decrements each cycle. At the edge where the counter is 0: res <= dp_a, the owner's done goes high for the next cycle, and the state goes to DONE.
- DONE: dp_b/dp_s still driven with the latched operand. Go to IDLE at the next edge unconditionally. No arbitration occurs in DONE.
- In IDLE, dp_b = 0 and dp_s = 0.
- The owning requester must deassert req during its gnt cycle. A req still high in IDLE is treated as a new request.
- din/sel changes after the grant edge have no effect on the operation in flight.
- Never both gnt0 and gnt1 high, and never both done0 and done1 high.

## Timing
- Reset values: state IDLE; dp_b 0; dp_s 0; res 0; gnt0/gnt1/done0/done1 0; busy 0; last 1; counter 0.
- Request sampled at edge E0 gives:
  - gnt in cycle E0..E0+1.
  - DRIVE in cycles E0..E0+S, where S = SETTLE_CYCLES.
  - res updated and done high in cycle E0+S..E0+S+1 (DONE).
  - IDLE at E0+S+1.
  - Earliest next grant edge is E0+S+2.
- Throughput: one operation per SETTLE_CYCLES+2 cycles under continuous demand. Under continuous demand from both requesters, grants alternate.
- rst asserted mid-operation clears all state immediately. No done is issued for the aborted operation, and the requester must re-request.
- A request arriving while busy waits; it is not lost provided req stays high.

## Configuration
- Q1_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins a tie; `last` is not used for the decision.
  - Undefined (default): round-robin as above.
  - All other behaviour and timing are identical in both builds.

## Test plan
- The bench models the datapath as dp_a = dp_s ? ~dp_b : dp_b (combinational).
- Reset check: after rst, all outputs 0 and busy 0. Assert rst mid-DRIVE: outputs return to 0 asynchronously and no done fires.
- Single request, SETTLE_CYCLES=1: req0=1, din0=4'b0110, sel0=1 at edge E0.
  - gnt0 high in cycle 1 and dp_b=0110 during DRIVE.
  - done0 in cycle 2 with res=4'b1001.
  - busy low from cycle 3.
- Tie, round-robin:
  - req0 and req1 both high from reset: grant order is 0,1,0,1, with done pulses in matching order.
  - With Q1_ARB_FIXED_PRIO_EN defined: requester 0 is always granted while req0 is re-raised.
- Settle length, SETTLE_CYCLES=4: req1, din1=4'b1010, sel1=0.
  - dp_b held at 1010 for 4 DRIVE cycles.
  - done1 exactly 4 cycles after gnt1 with res=1010.
  - dp_b=0 after returning to IDLE.
- Operand isolation: change din0 from 0011 to 1111 in the gnt0 cycle. res equals the result for 0011.
- Request while busy: req1 rises during requester 0's DRIVE and is held. gnt1 fires at E0+S+2, and res holds requester 0's result until requester 1's capture.
